trng_sample_ctrl: RTL and testbench
===================================

Name: trng_sample_ctrl

Overview:
Controller that sequences the mux-tree TRNG entropy source. It steps the 3-bit select, waits a settle window, then samples the raw bit through a 2-flop synchroniser. Samples are debiased (von Neumann), packed into words and delivered over a valid/ready interface. A repetition-count health test flags a stuck source. It sits between the TRNG core and any consumer (UART dump, seed register).

Parameters:
WORD_W, 8, output word width in bits (>=2).
SETTLE, 4, cycles between a select change and sampling (>=2; covers synchroniser latency).
REP_LIMIT, 16, consecutive identical raw samples that raise fault (>=2).

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous, active-high reset.
en  input  1  run enable.
trng_bit  input  1  raw entropy bit from the TRNG core (asynchronous).
sel  output  3  select driven to the TRNG mux tree.
data  output  WORD_W  packed random word.
valid  output  1  data is valid.
ready  input  1  consumer accepts data when valid&ready.
fault  output  1  sticky health-test failure.
fault_clr  input  1  clears fault; ignored outside FAULT.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; sel=0, data=0, valid=0, fault=0. Synchroniser, settle counter, bit counter, repetition counter and von Neumann pair flag are all cleared. Reset overrides everything, including mid-word and mid-handshake.
- Synchroniser: trng_bit passes through 2 flops; "raw" means the second flop's output.
- IDLE: if en=1, go to SETTLE with settle counter=0.
- SETTLE: counter increments each cycle; after SETTLE cycles in this state, go to SAMPLE.
- SAMPLE (one cycle): capture raw and set sel<=sel+1 (7 wraps to 0). Next state is SETTLE, HOLD or FAULT, per the rules below. One raw sample costs SETTLE+1 cycles.
- Von Neumann: pair flag toggles on every raw sample.
  - First sample of a pair is stored.
  - On the second: if it differs from the first, the first bit is accepted; if equal, both are discarded.
- Packing: an accepted bit shifts in as data <= {data[WORD_W-2:0], bit}, and the bit counter increments. When the counter reaches WORD_W: go to HOLD, valid=1, bit counter=0.
- Repetition test on raw samples:
  - Count is set to 1 on the first sample after IDLE, incremented when raw equals the previous raw, else reset to 1.
  - When the count reaches REP_LIMIT, next state is FAULT.
  - FAULT has priority over word completion in the same SAMPLE cycle.
- HOLD: valid=1 and data stable; sel and sampling are frozen. On valid&ready, valid=0 next cycle. Then go to SETTLE if en=1, else IDLE. The pair flag and repetition count are preserved across HOLD.
- en=0 in SETTLE/SAMPLE: go to IDLE next cycle. The partial word is discarded (bit counter, pair flag and repetition count cleared; data retains its last value). sel holds its value.
- en=0 in HOLD: no effect until the handshake completes.
- FAULT: fault=1, valid=0, sel frozen. The partial word and all counters are cleared. fault_clr=1 causes fault=0 next cycle and a move to IDLE.
- Values visible on data while valid=0 are unspecified to the consumer.

Test Plan:
- Reset: rst=1 for 2 cycles mid-SETTLE, with valid=1 previously → after reset sel=0, valid=0, fault=0, data=0, state IDLE; nothing asserts while en=0.
- Bench ties trng_bit=sel[0] (pre-increment sel drives the sampled value; default params), en=1, ready=1 → raw samples 0,1,0,1,...; each pair yields 0.
  - Expected: valid pulses with data=0x00 after 16 raw samples.
  - First valid occurs 80 cycles after the en cycle + 1.
  - Fault never asserts.
- trng_bit=~sel[0] → data=0xFF every 16 raw samples. Hold ready=0 for 20 cycles: valid stays 1, data stays 0xFF and sel does not change until ready=1.
- trng_bit=sel[1] → raw 0,0,1,1,... All pairs are discarded, so valid never asserts; the repetition count never exceeds 2, so fault stays 0.
- trng_bit tied 1 → fault=1 after the 16th raw sample, with valid never asserted and sel frozen. Then fault_clr=1 for 1 cycle → fault=0 and the controller restarts from IDLE, faulting again after 16 more samples.
- Word in progress (bit counter=5), then en=0 for 1 cycle → IDLE. With en=1 again, the next valid word needs a full WORD_W fresh accepted bits. Separately, assert en=0 during HOLD → the word is still delivered, then IDLE.

Source files
------------

// File: rtl/trng_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trng_sample_ctrl
// Brief    : Sequences the mux-tree TRNG select, samples the synchronised raw
//            bit, von Neumann debiases, packs words and runs a repetition test.
// Revision : 1.0 - initial release
// ============================================================================
module trng_sample_ctrl #(
    parameter int WORD_W    = 8,
    parameter int SETTLE    = 4,
    parameter int REP_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              trng_bit,
    output logic [2:0]        sel,
    output logic [WORD_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              fault,
    input  logic              fault_clr
);

    localparam int c_set_w = $clog2(SETTLE);
    localparam int c_bit_w = $clog2(WORD_W + 1);
    localparam int c_rep_w = $clog2(REP_LIMIT + 1);

    localparam logic [c_set_w-1:0] c_settle_last = c_set_w'(SETTLE - 1);
    localparam logic [c_bit_w-1:0] c_word_bits   = c_bit_w'(WORD_W);
    localparam logic [c_rep_w-1:0] c_rep_limit   = c_rep_w'(REP_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_SAMPLE = 3'd2,
        S_HOLD   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sel_q, sel_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                fault_q, fault_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [c_set_w-1:0]  settle_cnt_q, settle_cnt_d;
    logic [c_bit_w-1:0]  bit_cnt_q, bit_cnt_d;
    logic [c_rep_w-1:0]  rep_cnt_q, rep_cnt_d;
    logic                pair_q, pair_d;
    logic                first_q, first_d;
    logic                prev_q, prev_d;

    logic                w_go_idle;
    logic [c_rep_w-1:0]  w_rep_next;
    logic [c_bit_w-1:0]  w_bits_next;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        data_d       = data_q;
        valid_d      = valid_q;
        fault_d      = fault_q;
        sync1_d      = trng_bit;
        sync2_d      = sync1_q;
        settle_cnt_d = settle_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        pair_d       = pair_q;
        first_d      = first_q;
        prev_d       = prev_q;
        w_go_idle    = 1'b0;
        w_rep_next   = '0;
        w_bits_next  = bit_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            S_SETTLE: begin
                if (!en) begin
                    w_go_idle = 1'b1;
                end else if (settle_cnt_q == c_settle_last) begin
                    state_d      = S_SAMPLE;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + c_set_w'(1);
                end
            end
            S_SAMPLE: begin
                if (!en) begin
                    w_go_idle = 1'b1;
                end else begin
                    sel_d  = sel_q + 3'd1;
                    prev_d = sync2_q;
                    pair_d = ~pair_q;
                    // A zero count marks the first sample since IDLE/FAULT.
                    if ((rep_cnt_q != '0) && (sync2_q == prev_q)) begin
                        w_rep_next = rep_cnt_q + c_rep_w'(1);
                    end else begin
                        w_rep_next = c_rep_w'(1);
                    end
                    rep_cnt_d = w_rep_next;
                    if (!pair_q) begin
                        first_d = sync2_q;
                    end else if (sync2_q != first_q) begin
                        data_d      = {data_q[WORD_W-2:0], first_q};
                        w_bits_next = bit_cnt_q + c_bit_w'(1);
                    end
                    bit_cnt_d = w_bits_next;
                    state_d   = S_SETTLE;
                    if (w_rep_next == c_rep_limit) begin
                        state_d   = S_FAULT;
                        fault_d   = 1'b1;
                        bit_cnt_d = '0;
                        pair_d    = 1'b0;
                        rep_cnt_d = '0;
                    end else if (w_bits_next == c_word_bits) begin
                        state_d   = S_HOLD;
                        valid_d   = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_HOLD: begin
                if (ready) begin
                    valid_d = 1'b0;
                    if (en) begin
                        state_d      = S_SETTLE;
                        settle_cnt_d = '0;
                    end else begin
                        w_go_idle = 1'b1;
                    end
                end
            end
            S_FAULT: begin
                valid_d = 1'b0;
                if (fault_clr) begin
                    fault_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every return to IDLE drops the partial word and restarts health state.
        if (w_go_idle) begin
            state_d      = S_IDLE;
            settle_cnt_d = '0;
            bit_cnt_d    = '0;
            pair_d       = 1'b0;
            rep_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            settle_cnt_q <= '0;
            bit_cnt_q    <= '0;
            rep_cnt_q    <= '0;
            pair_q       <= 1'b0;
            first_q      <= 1'b0;
            prev_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            settle_cnt_q <= settle_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            pair_q       <= pair_d;
            first_q      <= first_d;
            prev_q       <= prev_d;
        end
    end

    assign sel   = sel_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_trng_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trng_sample_ctrl
// Brief    : Directed and randomized self-checking bench for trng_sample_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trng_sample_ctrl;

    localparam int WORD_W = 8;
    localparam int NWORDS = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              trng_bit;
    logic [2:0]        sel;
    logic [WORD_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              fault;
    logic              fault_clr;

    int                tests = 0;
    int                fails = 0;
    int                mode  = 0;
    logic [7:0]        pattern = 8'h00;

    trng_sample_ctrl #(.WORD_W(WORD_W), .SETTLE(4), .REP_LIMIT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .trng_bit  (trng_bit),
        .sel       (sel),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .fault     (fault),
        .fault_clr (fault_clr)
    );

    always #5 clk = ~clk;

    // The entropy source is modelled as a fixed function of the select.
    always_comb begin
        case (mode)
            0:       trng_bit = sel[0];
            1:       trng_bit = ~sel[0];
            2:       trng_bit = sel[1];
            3:       trng_bit = 1'b1;
            default: trng_bit = pattern[sel];
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; ready = 1'b1; fault_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int n, output logic saw_fault);
        n = 0;
        saw_fault = 1'b0;
        do begin
            tick();
            n++;
            if (fault) saw_fault = 1'b1;
        end while (!valid && n < bound);
    endtask

    task automatic wait_fault(input int bound, output int n, output logic saw_valid);
        n = 0;
        saw_valid = 1'b0;
        do begin
            tick();
            n++;
            if (valid) saw_valid = 1'b1;
        end while (!fault && n < bound);
    endtask

    initial begin
        int         n;
        logic       flag;
        logic       flag2;
        logic       bits[$];
        logic [7:0] exp_q[$];
        logic [7:0] w;
        logic [7:0] obs_data;
        logic       obs_valid;
        int         got;

        // Reset values
        mode = 0;
        do_reset();
        check("reset_sel", sel, 0);
        check("reset_valid", valid, 0);
        check("reset_fault", fault, 0);
        check("reset_data", data, 0);

        // Alternating raw bits: each pair yields 0
        en = 1'b1;
        wait_valid(300, n, flag);
        check("alt_first_latency", n, 81);
        check("alt_data", data, 8'h00);
        check("alt_no_fault", flag, 0);
        wait_valid(300, n, flag);
        check("alt_second_gap", n, 81);
        check("alt_data2", data, 8'h00);

        // Inverted alternating: 0xFF words, back-pressure holds everything
        do_reset();
        mode  = 1;
        ready = 1'b0;
        en    = 1'b1;
        wait_valid(300, n, flag);
        check("inv_latency", n, 81);
        check("inv_data", data, 8'hFF);
        check("inv_sel_at_valid", sel, 0);
        flag2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!valid || data !== 8'hFF || sel !== 3'd0) flag2 = 1'b1;
        end
        check("hold_stable", flag2, 0);
        ready = 1'b1;
        tick();
        check("hold_release", valid, 0);

        // Reset in the middle of a settle window
        for (int i = 0; i < 6; i++) tick();
        check("pre_reset_sel", sel, 1);
        rst = 1'b1; en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("midreset_sel", sel, 0);
        check("midreset_valid", valid, 0);
        check("midreset_fault", fault, 0);
        check("midreset_data", data, 0);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid || fault || sel !== 3'd0) flag = 1'b1;
        end
        check("idle_quiet", flag, 0);

        // Equal pairs only: no output, no fault
        do_reset();
        mode = 2;
        en   = 1'b1;
        flag = 1'b0;
        flag2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (valid) flag = 1'b1;
            if (fault) flag2 = 1'b1;
        end
        check("pairs_eq_no_valid", flag, 0);
        check("pairs_eq_no_fault", flag2, 0);

        // Stuck source trips the repetition test
        do_reset();
        mode = 3;
        en   = 1'b1;
        wait_fault(300, n, flag);
        check("stuck_fault_latency", n, 81);
        check("stuck_no_valid", flag, 0);
        check("stuck_sel", sel, 0);
        for (int i = 0; i < 10; i++) tick();
        check("fault_sel_frozen", sel, 0);
        check("fault_sticky", fault, 1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("fault_cleared", fault, 0);
        wait_fault(300, n, flag);
        check("stuck_refault_latency", n, 81);
        check("stuck_refault_no_valid", flag, 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;

        // Partial word is discarded when en drops
        do_reset();
        mode = 0;
        en   = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 51; i++) begin
            tick();
            if (valid) flag = 1'b1;
        end
        check("partial_no_valid", flag, 0);
        en = 1'b0;
        tick();
        en = 1'b1;
        wait_valid(300, n, flag);
        check("restart_full_word", n, 81);
        check("restart_data", data, 8'h00);

        // en dropped during HOLD: word still delivered, then idle
        do_reset();
        mode  = 1;
        ready = 1'b0;
        en    = 1'b1;
        wait_valid(300, n, flag);
        en   = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!valid || data !== 8'hFF) flag = 1'b1;
        end
        check("hold_en_low_kept", flag, 0);
        ready = 1'b1;
        tick();
        check("hold_en_low_done", valid, 0);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid || sel !== 3'd0) flag = 1'b1;
        end
        check("hold_en_low_idle", flag, 0);

        // Random select-to-bit maps against a pair-level reference
        for (int it = 0; it < 6; it++) begin
            do begin
                pattern = 8'($urandom);
            end while (((pattern[0] ^ pattern[1]) | (pattern[2] ^ pattern[3]) |
                        (pattern[4] ^ pattern[5]) | (pattern[6] ^ pattern[7])) == 1'b0);
            bits.delete();
            exp_q.delete();
            for (int k = 0; bits.size() < NWORDS * WORD_W; k++) begin
                if (pattern[(2 * k) % 8] != pattern[(2 * k + 1) % 8])
                    bits.push_back(pattern[(2 * k) % 8]);
            end
            for (int j = 0; j < NWORDS; j++) begin
                w = '0;
                for (int m = 0; m < WORD_W; m++) w[WORD_W - 1 - m] = bits[j * WORD_W + m];
                exp_q.push_back(w);
            end

            do_reset();
            mode = 4;
            en   = 1'b1;
            got  = 0;
            n    = 0;
            while (got < NWORDS && n < 4000) begin
                obs_valid = valid;
                obs_data  = data;
                ready     = 1'($urandom_range(0, 1));
                tick();
                n++;
                if (obs_valid && ready) begin
                    check("rand_word", obs_data, exp_q[got]);
                    got++;
                end
            end
            check("rand_word_count", got, NWORDS);
            check("rand_no_fault", fault, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
